// File: rtl/float_add_pipe_if.sv
// float_add_pipe_if: operand/result handshake bundle for the pipelined float adder.
interface float_add_pipe_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
   localparam int XLEN = 1 + EXP_W + MAN_W;
   logic            in_valid, in_ready, sub, out_valid, out_ready;
   logic            overflow, underflow, invalid;
   logic [XLEN-1:0] A, B, result;
   modport slave (input in_valid, A, B, sub, out_ready,
                  output in_ready, out_valid, result, overflow, underflow, invalid);
   modport master (output in_valid, A, B, sub, out_ready,
                   input in_ready, out_valid, result, overflow, underflow, invalid);
endinterface

// File: rtl/float_add_pipe.sv
// float_add_pipe: 3-stage IEEE-754-style adder/subtractor, RNE, flush-to-zero,
// special-value handling and exception flags, valid/ready with global stall.
module float_add_pipe #(parameter int EXP_W = 8, parameter int MAN_W = 23) (
   input logic clk,
   input logic rst,
   float_add_pipe_if.slave io
);
   localparam int X = 1 + EXP_W + MAN_W;
   localparam int W = MAN_W + 4;
   localparam logic [EXP_W-1:0] EMAX = '1;
   typedef struct packed {
      logic v, s, es, zs, sp, inv;
      logic [EXP_W-1:0] e;
      logic [W-1:0] mx, my;
      logic [X-1:0] sr;
   } st1_t;
   typedef struct packed {
      logic v, s, zs, sp, inv;
      logic [EXP_W-1:0] e;
      logic [W:0] sum;
      logic [X-1:0] sr;
   } st2_t;
   typedef struct packed {
      logic v, ovf, unf, inv;
      logic [X-1:0] res;
   } st3_t;
   st1_t st1_q, st1_d;
   st2_t st2_q, st2_d;
   st3_t st3_q, st3_d;
   logic rdy_q, en;
   logic sa, sb, nan_a, nan_b, inf_a, inf_b, nan, swap;
   logic [EXP_W-1:0] ea, eb, ex, ey, d;
   logic [MAN_W-1:0] fa, fb, fx, fy;
   logic [W-1:0] sig_y, shifted, mask;
   int ds, lz, ex_n, ex_r;
   logic [W-1:0] nrm;
   logic [MAN_W+1:0] mr;
   logic [MAN_W-1:0] frac;
   logic inc, nz;
   assign en = ~st3_q.v | io.out_ready;
   assign io.in_ready = rdy_q & en;
   assign io.out_valid = st3_q.v;
   assign io.result = st3_q.res;
   assign io.overflow = st3_q.ovf;
   assign io.underflow = st3_q.unf;
   assign io.invalid = st3_q.inv;
   // Stage 1: unpack (denormals flushed), specials, swap so |X|>=|Y|, align Y.
   always_comb begin
      sa = io.A[X-1];
      sb = io.B[X-1] ^ io.sub;
      ea = io.A[X-2:MAN_W];
      eb = io.B[X-2:MAN_W];
      fa = io.A[MAN_W-1:0];
      fb = io.B[MAN_W-1:0];
      nan_a = &ea & |fa;
      nan_b = &eb & |fb;
      inf_a = &ea & ~|fa;
      inf_b = &eb & ~|fb;
      nan = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
      swap = (~|eb ? '0 : {eb, fb}) > (~|ea ? '0 : {ea, fa});
      ex = swap ? eb : ea;
      ey = swap ? ea : eb;
      fx = swap ? fb : fa;
      fy = swap ? fa : fb;
      d = ex - ey;
      ds = (int'(d) > W) ? W : int'(d);
      sig_y = ~|ey ? '0 : {1'b1, fy, 3'b000};
      shifted = sig_y >> ds;
      mask = {W{1'b1}} << ds;
      st1_d.v = io.in_valid & io.in_ready;
      st1_d.s = swap ? sb : sa;
      st1_d.es = sa ^ sb;
      st1_d.zs = sa & sb;
      st1_d.sp = nan | inf_a | inf_b;
      st1_d.inv = nan;
      st1_d.e = ex;
      st1_d.mx = ~|ex ? '0 : {1'b1, fx, 3'b000};
      st1_d.my = {shifted[W-1:1], shifted[0] | |(sig_y & ~mask)};
      st1_d.sr = nan ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} : {inf_a ? sa : sb, EMAX, {MAN_W{1'b0}}};
   end
   always_comb begin
      st2_d.v = st1_q.v;
      st2_d.s = st1_q.s;
      st2_d.zs = st1_q.zs;
      st2_d.sp = st1_q.sp;
      st2_d.inv = st1_q.inv;
      st2_d.e = st1_q.e;
      st2_d.sr = st1_q.sr;
      st2_d.sum = st1_q.es ? {1'b0, st1_q.mx} - {1'b0, st1_q.my} : {1'b0, st1_q.mx} + {1'b0, st1_q.my};
   end
   // Stage 3: normalise, round half-to-even on guard/round/sticky, pack, flag.
   always_comb begin
      lz = 0;
      for (int i = 0; i < W; i++) lz = st2_q.sum[i] ? W - 1 - i : lz;
      nz = |st2_q.sum;
      nrm = st2_q.sum[W] ? {st2_q.sum[W:2], |st2_q.sum[1:0]} : st2_q.sum[W-1:0] << lz;
      ex_n = st2_q.sum[W] ? int'(st2_q.e) + 1 : int'(st2_q.e) - lz;
      inc = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
      mr = {1'b0, nrm[W-1:3]} + (MAN_W+2)'(inc);
      ex_r = ex_n + int'(mr[MAN_W+1]);
      frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
      st3_d.v = st2_q.v;
      st3_d.inv = st2_q.v & st2_q.sp & st2_q.inv;
      st3_d.ovf = st2_q.v & ~st2_q.sp & nz & (ex_r >= int'(EMAX));
      st3_d.unf = st2_q.v & ~st2_q.sp & nz & (ex_r < 1);
      st3_d.res = st2_q.sp ? st2_q.sr
                : ~nz ? {st2_q.zs, {(X-1){1'b0}}}
                : (ex_r >= int'(EMAX)) ? {st2_q.s, EMAX, {MAN_W{1'b0}}}
                : (ex_r < 1) ? {st2_q.s, {(X-1){1'b0}}}
                : {st2_q.s, ex_r[EXP_W-1:0], frac};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q <= 1'b0;
         st1_q <= '0;
         st2_q <= '0;
         st3_q <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (en) begin
            st1_q <= st1_d;
            st2_q <= st2_d;
            st3_q <= st3_d;
         end
      end
   end
endmodule

// File: tb/tb_float_add_pipe.sv
// tb_float_add_pipe: directed vector table plus streaming, backpressure and reset sequences.
module tb_float_add_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   float_add_pipe_if #(.EXP_W(8), .MAN_W(23)) io ();
   float_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .io(io));
   typedef struct {
      logic [31:0] a, b;
      logic        s;
      logic [31:0] r;
      logic [2:0]  f;
   } vec_t;
   vec_t v [23];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] flags();
      return {29'b0, io.overflow, io.underflow, io.invalid};
   endfunction
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic [2:0] f, output int lat);
      io.A = a;
      io.B = b;
      io.sub = s;
      io.in_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         io.in_valid = 1'b0;
         lat++;
      end while (!io.out_valid && lat < 20);
      r = io.result;
      f = {io.overflow, io.underflow, io.invalid};
   endtask
   initial begin
      logic [31:0] r;
      logic [2:0] f;
      int lat, sent, got, seen;
      bit acc;
      v[0]  = '{32'h404CCCCD, 32'h40866666, 1'b0, 32'h40ECCCCC, 3'b000};
      v[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
      v[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
      v[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001};
      v[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100};
      v[5]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010};
      v[6]  = '{32'hBF000000, 32'h40CCCCCD, 1'b0, 32'h40BCCCCD, 3'b000};
      v[7]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
      v[8]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
      v[9]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
      v[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001};
      v[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
      v[12] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000};
      v[13] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001};
      v[14] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
      v[15] = '{32'h00000001, 32'h80000001, 1'b0, 32'h00000000, 3'b000};
      v[16] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000};
      v[17] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000};
      v[18] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000};
      v[19] = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 3'b100};
      v[20] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000};
      v[21] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000};
      v[22] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      io.sub = 1'b0;
      io.A = '0;
      io.B = '0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
      check("rst_result", io.result, 32'd0);
      check("rst_flags", flags(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", {31'b0, io.in_ready}, 32'd1);
      for (int i = 0; i < 23; i++) begin
         run_op(v[i].a, v[i].b, v[i].s, r, f, lat);
         check($sformatf("vec%0d_latency", i), lat, 32'd3);
         check($sformatf("vec%0d_result", i), r, v[i].r);
         check($sformatf("vec%0d_flags", i), {29'b0, f}, {29'b0, v[i].f});
      end
      @(negedge clk);
      // Eight back-to-back operations with the consumer stalled in cycles 4..6.
      sent = 0;
      got = 0;
      acc = 1'b0;
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (acc) sent++;
         io.out_ready = !(c >= 4 && c <= 6);
         io.in_valid = sent < 8;
         io.A = v[sent % 8].a;
         io.B = v[sent % 8].b;
         io.sub = v[sent % 8].s;
         #1;
         if (c < 10) check($sformatf("stream_in_ready_c%0d", c), {31'b0, io.in_ready}, {31'b0, io.out_ready});
         if (io.out_valid) begin
            check($sformatf("stream_res%0d_c%0d", got, c), io.result, v[got].r);
            check($sformatf("stream_flg%0d_c%0d", got, c), flags(), {29'b0, v[got].f});
            if (io.out_ready) got++;
         end
         acc = io.in_valid && io.in_ready;
      end
      @(negedge clk);
      io.in_valid = 1'b0;
      io.out_ready = 1'b1;
      check("stream_sent", sent, 32'd8);
      check("stream_got", got, 32'd8);
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (io.out_valid) seen++;
      end
      check("stream_no_dup", seen, 32'd0);
      // Reset with one result at the output and two operations in flight.
      for (int c = 0; c < 3; c++) begin
         io.in_valid = 1'b1;
         io.A = v[8].a;
         io.B = v[8].b;
         io.sub = v[8].s;
         @(negedge clk);
      end
      io.in_valid = 1'b0;
      check("pre_rst_out_valid", {31'b0, io.out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'b0, io.out_valid}, 32'd0);
      check("async_rst_result", io.result, 32'd0);
      check("async_rst_flags", flags(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (io.out_valid) seen++;
      end
      check("no_stale_after_rst", seen, 32'd0);
      run_op(v[6].a, v[6].b, v[6].s, r, f, lat);
      check("post_rst_latency", lat, 32'd3);
      check("post_rst_result", r, v[6].r);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
